// File: rtl/ex_result_buffer.sv
// EX->WB result buffer: 2-entry in-order skid FIFO with valid/ready to writeback, the
// architectural C/Z flags, and two operand forwarding lookups over the buffered results.
module ex_result_buffer #(
  parameter int unsigned DW = 8,
  parameter int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic          ex_flush,
  input  logic [4:0]    alu_fn,
  input  logic [DW-1:0] alu_y,
  input  logic          alu_cout,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_we,
  output logic          flag_c,
  output logic          flag_z,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [DW-1:0] wb_data,
  output logic [RW-1:0] wb_rd,
  output logic          wb_we,
  input  logic [RW-1:0] rs_a,
  input  logic [RW-1:0] rs_b,
  output logic          fwd_a_hit,
  output logic          fwd_b_hit,
  output logic [DW-1:0] fwd_a_data,
  output logic [DW-1:0] fwd_b_data
);

  // Slot 0 is always the head; slot 1 (when valid) is always the younger entry.
  logic [1:0]          valid_q, valid_d;
  logic [1:0][DW-1:0]  data_q, data_d;
  logic [1:0][RW-1:0]  rd_q, rd_d;
  logic [1:0]          we_q, we_d;
  logic                c_q, c_d;
  logic                z_q, z_d;
  logic                enq, deq;

  assign ex_ready = ~valid_q[1];
  assign wb_valid = valid_q[0];
  assign wb_data  = data_q[0];
  assign wb_rd    = rd_q[0];
  assign wb_we    = we_q[0];
  assign flag_c   = c_q;
  assign flag_z   = z_q;

  assign enq = ex_valid & ex_ready & ~ex_flush;
  assign deq = wb_valid & wb_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    rd_d    = rd_q;
    we_d    = we_q;
    c_d     = c_q;
    z_d     = z_q;

    if (deq) begin
      valid_d    = {1'b0, valid_q[1]};
      data_d[0]  = data_q[1];
      rd_d[0]    = rd_q[1];
      we_d[0]    = we_q[1];
    end

    if (enq) begin
      // Lands behind whatever survives this cycle's dequeue.
      if (valid_q[0] && !deq) begin
        valid_d[1] = 1'b1;
        data_d[1]  = alu_y;
        rd_d[1]    = ex_rd;
        we_d[1]    = ex_we;
      end else begin
        valid_d[0] = 1'b1;
        data_d[0]  = alu_y;
        rd_d[0]    = ex_rd;
        we_d[0]    = ex_we;
      end

      // fn[3:2]: 00 arith, 01 logic, 10 shift/rotate, 11 and fn>=16 leave flags alone.
      if (!alu_fn[4]) begin
        unique case (alu_fn[3:2])
          2'b00, 2'b10: begin
            c_d = alu_cout;
            z_d = (alu_y == '0);
          end
          2'b01:   z_d = (alu_y == '0);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      we_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  // Returns {hit, data}; the younger slot takes priority.
  function automatic logic [DW:0] lookup(input logic [RW-1:0] rs);
    logic [DW:0] res;
    res = '0;
    if (valid_q[0] && we_q[0] && (rd_q[0] == rs)) res = {1'b1, data_q[0]};
    if (valid_q[1] && we_q[1] && (rd_q[1] == rs)) res = {1'b1, data_q[1]};
    return res;
  endfunction

  always_comb begin
    {fwd_a_hit, fwd_a_data} = lookup(rs_a);
    {fwd_b_hit, fwd_b_data} = lookup(rs_b);
  end

endmodule

// File: tb/tb_ex_result_buffer.sv
// Directed self-checking bench for ex_result_buffer: handshake, ordering, flags,
// forwarding, flush and asynchronous reset.
module tb_ex_result_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ex_valid = 1'b0, ex_flush = 1'b0, alu_cout = 1'b0, ex_we = 1'b0;
  logic [4:0] alu_fn = '0;
  logic [7:0] alu_y = '0;
  logic [2:0] ex_rd = '0, rs_a = '0, rs_b = '0;
  logic       wb_ready = 1'b0;
  logic       ex_ready, flag_c, flag_z, wb_valid, wb_we;
  logic [7:0] wb_data, fwd_a_data, fwd_b_data;
  logic [2:0] wb_rd;
  logic       fwd_a_hit, fwd_b_hit;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ex_result_buffer #(.DW(8), .RW(3)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_flush(ex_flush),
    .alu_fn(alu_fn), .alu_y(alu_y), .alu_cout(alu_cout), .ex_rd(ex_rd), .ex_we(ex_we),
    .flag_c(flag_c), .flag_z(flag_z), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we), .rs_a(rs_a), .rs_b(rs_b),
    .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit), .fwd_a_data(fwd_a_data),
    .fwd_b_data(fwd_b_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [4:0] fn, input logic [7:0] y, input logic cout,
                          input logic [2:0] rd, input logic we);
    ex_valid = 1'b1;
    alu_fn   = fn;
    alu_y    = y;
    alu_cout = cout;
    ex_rd    = rd;
    ex_we    = we;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid: got %b exp 0", wb_valid); end
    n_checks++; if (flag_c !== 1'b0 || flag_z !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got c=%b z=%b exp 0 0", flag_c, flag_z); end
    n_checks++; if (wb_data !== 8'h00 || wb_rd !== 3'd0 || wb_we !== 1'b0) begin n_fail++; $display("FAIL rst_wb_fields: got %h %0d %b exp 00 0 0", wb_data, wb_rd, wb_we); end
    n_checks++; if (fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b0) begin n_fail++; $display("FAIL rst_fwd_hit: got %b %b exp 0 0", fwd_a_hit, fwd_b_hit); end
    step();
    rst_n = 1'b1;
    step();
    n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ex_ready: got %b exp 1", ex_ready); end
  endtask

  task automatic test_add();
    wb_ready = 1'b1;
    drive_ex(5'd0, 8'h00, 1'b1, 3'd2, 1'b1);
    step();
    ex_valid = 1'b0;
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL add_wb_valid: got %b exp 1", wb_valid); end
    n_checks++; if (wb_data !== 8'h00 || wb_rd !== 3'd2 || wb_we !== 1'b1) begin n_fail++; $display("FAIL add_wb_fields: got %h %0d %b exp 00 2 1", wb_data, wb_rd, wb_we); end
    n_checks++; if (flag_c !== 1'b1 || flag_z !== 1'b1) begin n_fail++; $display("FAIL add_flags: got c=%b z=%b exp 1 1", flag_c, flag_z); end
    step();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL add_retired: got %b exp 0", wb_valid); end
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b0;
    drive_ex(5'd4, 8'h11, 1'b0, 3'd1, 1'b1);
    step();
    drive_ex(5'd4, 8'h22, 1'b0, 3'd2, 1'b1);
    step();
    n_checks++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b exp 0", ex_ready); end
    // Held instruction would clear C if it were wrongly accepted while stalled.
    drive_ex(5'd0, 8'h33, 1'b0, 3'd3, 1'b1);
    step();
    step();
    n_checks++; if (wb_data !== 8'h11 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_head_stable: got %h v=%b exp 11 1", wb_data, wb_valid); end
    n_checks++; if (flag_c !== 1'b1 || flag_z !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_flags: got c=%b z=%b exp 1 0", flag_c, flag_z); end
    wb_ready = 1'b1;
    step();
    n_checks++; if (wb_data !== 8'h22 || ex_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %h rdy=%b exp 22 1", wb_data, ex_ready); end
    step();
    ex_valid = 1'b0;
    n_checks++; if (wb_data !== 8'h33 || wb_rd !== 3'd3 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_third: got %h rd=%0d v=%b exp 33 3 1", wb_data, wb_rd, wb_valid); end
    n_checks++; if (flag_c !== 1'b0) begin n_fail++; $display("FAIL b2b_late_flag_c: got %b exp 0", flag_c); end
    step();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b exp 0", wb_valid); end
  endtask

  // Starting flags C=0 Z=0; each row is accepted and retired with wb_ready=1.
  logic [4:0] t_fn[8]   = '{5'd4, 5'd12, 5'd2, 5'd7, 5'd8, 5'd3, 5'd11, 5'd31};
  logic [7:0] t_y[8]    = '{8'h00, 8'h05, 8'h03, 8'h00, 8'h80, 8'h00, 8'h01, 8'h00};
  logic       t_cout[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic       t_c[8]    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       t_z[8]    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic test_flags();
    wb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_ex(t_fn[i], t_y[i], t_cout[i], 3'd4, 1'b1);
      step();
      n_checks++; if (flag_c !== t_c[i] || flag_z !== t_z[i]) begin n_fail++; $display("FAIL flags_fn%0d: got c=%b z=%b exp %b %b", t_fn[i], flag_c, flag_z, t_c[i], t_z[i]); end
      n_checks++; if (wb_data !== t_y[i] || wb_valid !== 1'b1) begin n_fail++; $display("FAIL flags_entry_fn%0d: got %h v=%b exp %h 1", t_fn[i], wb_data, wb_valid, t_y[i]); end
    end
    ex_valid = 1'b0;
    step();
  endtask

  task automatic test_forward();
    wb_ready = 1'b0;
    drive_ex(5'd12, 8'h10, 1'b0, 3'd3, 1'b1);
    step();
    drive_ex(5'd12, 8'h20, 1'b0, 3'd3, 1'b1);
    step();
    ex_valid = 1'b0;
    rs_a = 3'd3;
    rs_b = 3'd4;
    #1;
    n_checks++; if (fwd_a_hit !== 1'b1 || fwd_a_data !== 8'h20) begin n_fail++; $display("FAIL fwd_youngest: got %b %h exp 1 20", fwd_a_hit, fwd_a_data); end
    n_checks++; if (fwd_b_hit !== 1'b0 || fwd_b_data !== 8'h00) begin n_fail++; $display("FAIL fwd_miss: got %b %h exp 0 00", fwd_b_hit, fwd_b_data); end
    wb_ready = 1'b1;
    step();
    step();
    wb_ready = 1'b0;
    n_checks++; if (fwd_a_hit !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_empty: got hit=%b v=%b exp 0 0", fwd_a_hit, wb_valid); end
    drive_ex(5'd12, 8'h55, 1'b0, 3'd5, 1'b1);
    step();
    drive_ex(5'd12, 8'h66, 1'b0, 3'd6, 1'b0);
    ex_rd = 3'd5;
    rs_a = 3'd5;
    rs_b = 3'd5;
    #1;
    n_checks++; if (fwd_a_hit !== 1'b1 || fwd_a_data !== 8'h55) begin n_fail++; $display("FAIL fwd_single: got %b %h exp 1 55", fwd_a_hit, fwd_a_data); end
    ex_we = 1'b1;
    rs_b = 3'd6;
    ex_rd = 3'd6;
    #1;
    n_checks++; if (fwd_b_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_ex_invisible: got %b exp 0", fwd_b_hit); end
    ex_rd = 3'd5;
    ex_we = 1'b0;
    step();
    ex_valid = 1'b0;
    n_checks++; if (fwd_a_hit !== 1'b1 || fwd_a_data !== 8'h55) begin n_fail++; $display("FAIL fwd_we0_ignored: got %b %h exp 1 55", fwd_a_hit, fwd_a_data); end
    wb_ready = 1'b1;
    step();
    step();
  endtask

  task automatic test_flush();
    wb_ready = 1'b0;
    drive_ex(5'd12, 8'h44, 1'b0, 3'd1, 1'b1);
    step();
    drive_ex(5'd2, 8'h00, 1'b1, 3'd2, 1'b1);
    ex_flush = 1'b1;
    step();
    ex_valid = 1'b0;
    ex_flush = 1'b0;
    n_checks++; if (flag_c !== 1'b0 || flag_z !== 1'b0) begin n_fail++; $display("FAIL flush_flags: got c=%b z=%b exp 0 0", flag_c, flag_z); end
    n_checks++; if (ex_ready !== 1'b1 || wb_data !== 8'h44) begin n_fail++; $display("FAIL flush_buffer: got rdy=%b %h exp 1 44", ex_ready, wb_data); end
    wb_ready = 1'b1;
    step();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_enq: got %b exp 0", wb_valid); end
  endtask

  task automatic test_simul_and_reset();
    wb_ready = 1'b0;
    drive_ex(5'd12, 8'hA1, 1'b0, 3'd1, 1'b1);
    step();
    drive_ex(5'd12, 8'hA2, 1'b0, 3'd2, 1'b1);
    wb_ready = 1'b1;
    step();
    ex_valid = 1'b0;
    n_checks++; if (wb_data !== 8'hA2 || wb_valid !== 1'b1 || ex_ready !== 1'b1) begin n_fail++; $display("FAIL simul_head: got %h v=%b rdy=%b exp a2 1 1", wb_data, wb_valid, ex_ready); end
    step();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL simul_count1: got %b exp 0", wb_valid); end
    wb_ready = 1'b0;
    drive_ex(5'd0, 8'h00, 1'b1, 3'd7, 1'b1);
    step();
    step();
    ex_valid = 1'b0;
    n_checks++; if (flag_c !== 1'b1 || ex_ready !== 1'b0) begin n_fail++; $display("FAIL pre_reset: got c=%b rdy=%b exp 1 0", flag_c, ex_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (wb_valid !== 1'b0 || flag_c !== 1'b0 || flag_z !== 1'b0) begin n_fail++; $display("FAIL async_reset: got v=%b c=%b z=%b exp 0 0 0", wb_valid, flag_c, flag_z); end
    n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_ready: got %b exp 1", ex_ready); end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_flags();
    test_forward();
    test_flush();
    test_simul_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
